// File: rtl/lockstep_pkg.sv
// Shared types and limits for the cluster lockstep checker.
package lockstep_pkg;

   localparam int LOCKSTEP_MAX_DELAY = 8;
   localparam int LOCKSTEP_ADDR_W    = 32;
   localparam int LOCKSTEP_DATA_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2,
      ST_FAULT = 2'd3
   } lockstep_state_e;

   typedef struct packed {
      logic                           req;
      logic                           wen;
      logic [LOCKSTEP_DATA_W/8-1:0]   be;
      logic [LOCKSTEP_ADDR_W-1:0]     addr;
      logic [LOCKSTEP_DATA_W-1:0]     wdata;
   } lockstep_req_sig_t;

endpackage

// File: rtl/lockstep_delay_line.sv
// Fixed-depth register pipeline with synchronous active-low clear.
module lockstep_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/lockstep_checker.sv
// Master/shadow core lockstep comparator with mismatch counter and sticky fault.
// Define LOCKSTEP_CHECK_RDATA_EN to also compare read responses {rvalid, rdata}.
module lockstep_checker
   import lockstep_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DELAY      = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cfg_en_i,
   input  logic                    cfg_clr_i,
   input  logic [CNT_WIDTH-1:0]    cfg_thresh_i,
   input  logic                    m_req_i,
   input  logic                    m_wen_i,
   input  logic [ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [DATA_WIDTH-1:0]   m_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] m_be_i,
   input  logic                    s_req_i,
   input  logic                    s_wen_i,
   input  logic [ADDR_WIDTH-1:0]   s_addr_i,
   input  logic [DATA_WIDTH-1:0]   s_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] s_be_i,
   input  logic                    m_rvalid_i,
   input  logic                    s_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   m_rdata_i,
   input  logic [DATA_WIDTH-1:0]   s_rdata_i,
   output logic                    mismatch_o,
   output logic                    fault_o,
   output logic                    irq_o,
   output logic [CNT_WIDTH-1:0]    err_cnt_o,
   output logic [ADDR_WIDTH-1:0]   fault_addr_o,
   output logic [1:0]              state_o
);

   localparam int SIG_W  = 2 + DATA_WIDTH/8 + ADDR_WIDTH + DATA_WIDTH;
   localparam int FILL_W = $clog2(LOCKSTEP_MAX_DELAY + 1);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DELAY - 1);

   lockstep_state_e        r_state, w_state_nxt;
   logic [FILL_W-1:0]      r_fill_cnt;
   logic [CNT_WIDTH-1:0]   r_err_cnt, w_cnt_inc, w_thresh_eff;
   logic [ADDR_WIDTH-1:0]  r_fault_addr;
   logic                   r_first_seen, r_mismatch, r_irq;
   logic [SIG_W-1:0]       w_m_sig, w_s_sig, w_m_sig_d;
   logic                   w_req_mis, w_rd_mis, w_mis_hit;

   assign w_m_sig = {m_req_i, m_wen_i, m_be_i, m_addr_i, m_wdata_i};
   assign w_s_sig = {s_req_i, s_wen_i, s_be_i, s_addr_i, s_wdata_i};

   lockstep_delay_line #(.WIDTH(SIG_W), .DEPTH(DELAY)) u_req_dly (
      .i_clk   (clk_i),
      .i_clr_n (rst_ni),
      .i_d     (w_m_sig),
      .o_q     (w_m_sig_d)
   );

   // When neither side requests, the remaining fields are don't-care.
   assign w_req_mis = (w_m_sig_d[SIG_W-1] | s_req_i) & (w_m_sig_d != w_s_sig);

`ifdef LOCKSTEP_CHECK_RDATA_EN
   logic [DATA_WIDTH:0] w_m_rd_d;

   lockstep_delay_line #(.WIDTH(DATA_WIDTH+1), .DEPTH(DELAY)) u_rd_dly (
      .i_clk   (clk_i),
      .i_clr_n (rst_ni),
      .i_d     ({m_rvalid_i, m_rdata_i}),
      .o_q     (w_m_rd_d)
   );

   assign w_rd_mis = (w_m_rd_d[DATA_WIDTH] | s_rvalid_i) &
                     (w_m_rd_d != {s_rvalid_i, s_rdata_i});
`else
   logic w_unused;
   assign w_unused = ^{m_rvalid_i, s_rvalid_i, m_rdata_i, s_rdata_i};
   assign w_rd_mis = 1'b0;
`endif

   // Clear beats a same-cycle mismatch: it is neither counted nor pulsed.
   assign w_mis_hit    = (r_state == ST_CHECK) & (w_req_mis | w_rd_mis) & ~cfg_clr_i;
   assign w_cnt_inc    = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + CNT_WIDTH'(1);
   assign w_thresh_eff = (cfg_thresh_i == '0) ? CNT_WIDTH'(1) : cfg_thresh_i;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (cfg_en_i) w_state_nxt = ST_FILL;
         ST_FILL:  if (r_fill_cnt == FILL_LAST) w_state_nxt = ST_CHECK;
         ST_CHECK: if (w_mis_hit && (w_cnt_inc >= w_thresh_eff)) w_state_nxt = ST_FAULT;
         ST_FAULT: if (cfg_clr_i) w_state_nxt = ST_FILL;
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (!cfg_en_i) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_fill_cnt   <= '0;
         r_err_cnt    <= '0;
         r_fault_addr <= '0;
         r_first_seen <= 1'b0;
         r_mismatch   <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_cnt <= (r_state == ST_FILL) ? r_fill_cnt + FILL_W'(1) : '0;
         r_mismatch <= w_mis_hit;
         r_irq      <= (r_state != ST_FAULT) && (w_state_nxt == ST_FAULT);
         if (cfg_clr_i) begin
            r_err_cnt    <= '0;
            r_fault_addr <= '0;
            r_first_seen <= 1'b0;
         end else if (w_mis_hit) begin
            r_err_cnt <= w_cnt_inc;
            if (!r_first_seen) begin
               r_fault_addr <= w_m_sig_d[DATA_WIDTH +: ADDR_WIDTH];
               r_first_seen <= 1'b1;
            end
         end
      end
   end

   assign mismatch_o   = r_mismatch;
   assign fault_o      = (r_state == ST_FAULT);
   assign irq_o        = r_irq;
   assign err_cnt_o    = r_err_cnt;
   assign fault_addr_o = r_fault_addr;
   assign state_o      = r_state;

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: expected mismatch cycles are queued at drive time.
module tb_lockstep_checker;
   import lockstep_pkg::*;

   localparam int DELAY = 2;
`ifdef LOCKSTEP_CHECK_RDATA_EN
   localparam logic RD_EXP = 1'b1;
`else
   localparam logic RD_EXP = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni, cfg_en_i, cfg_clr_i;
   logic [15:0] cfg_thresh_i;
   logic        m_req_i, m_wen_i, s_req_i, s_wen_i;
   logic [31:0] m_addr_i, m_wdata_i, s_addr_i, s_wdata_i;
   logic [3:0]  m_be_i, s_be_i;
   logic        m_rvalid_i, s_rvalid_i;
   logic [31:0] m_rdata_i, s_rdata_i;
   logic        mismatch_o, fault_o, irq_o;
   logic [15:0] err_cnt_o;
   logic [31:0] fault_addr_o;
   logic [1:0]  state_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   lockstep_req_sig_t hist[$];
   int                exp_q[$];
   lockstep_req_sig_t idle_sig;

   always #5 clk_i = ~clk_i;

   lockstep_checker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DELAY(DELAY), .CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
      .cfg_thresh_i(cfg_thresh_i),
      .m_req_i(m_req_i), .m_wen_i(m_wen_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
      .s_req_i(s_req_i), .s_wen_i(s_wen_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
      .m_rvalid_i(m_rvalid_i), .s_rvalid_i(s_rvalid_i), .m_rdata_i(m_rdata_i), .s_rdata_i(s_rdata_i),
      .mismatch_o(mismatch_o), .fault_o(fault_o), .irq_o(irq_o), .err_cnt_o(err_cnt_o),
      .fault_addr_o(fault_addr_o), .state_o(state_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic exp_now;
      @(posedge clk_i);
      #1;
      cyc++;
      exp_now = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (exp_now) void'(exp_q.pop_front());
      if (exp_now || mismatch_o) chk("mismatch_o", 64'(mismatch_o), 64'(exp_now));
   endtask

   // Shadow replays the master stream DELAY cycles later; corrupt[0] flips wdata, corrupt[1] flips addr.
   task automatic cycle(input lockstep_req_sig_t m, input logic [1:0] corrupt, input logic exp);
      lockstep_req_sig_t s;
      hist.push_back(m);
      s = hist.pop_front();
      if (corrupt[0]) s.wdata = s.wdata ^ 32'h1;
      if (corrupt[1]) s.addr  = s.addr ^ 32'h10;
      m_req_i = m.req; m_wen_i = m.wen; m_be_i = m.be; m_addr_i = m.addr; m_wdata_i = m.wdata;
      s_req_i = s.req; s_wen_i = s.wen; s_be_i = s.be; s_addr_i = s.addr; s_wdata_i = s.wdata;
      if (exp) exp_q.push_back(cyc + 1);
      tick();
   endtask

   function automatic lockstep_req_sig_t mk(input logic req, input logic [31:0] a, input logic [31:0] d);
      lockstep_req_sig_t r;
      r.req = req; r.wen = 1'b0; r.be = 4'hF; r.addr = a; r.wdata = d;
      return r;
   endfunction

   initial begin
      lockstep_req_sig_t rnd;
      idle_sig = '0;
      for (int i = 0; i < DELAY; i++) hist.push_back(idle_sig);
      rst_ni = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0; cfg_thresh_i = 16'd1;
      m_rvalid_i = 1'b0; s_rvalid_i = 1'b0; m_rdata_i = '0; s_rdata_i = '0;

      // reset
      for (int i = 0; i < 3; i++) cycle(idle_sig, 2'b00, 1'b0);
      chk("rst_state", 64'(state_o), 64'd0);
      chk("rst_fault", 64'(fault_o), 64'd0);
      chk("rst_irq", 64'(irq_o), 64'd0);
      chk("rst_mis", 64'(mismatch_o), 64'd0);
      chk("rst_cnt", 64'(err_cnt_o), 64'd0);
      chk("rst_faddr", 64'(fault_addr_o), 64'd0);
      rst_ni = 1'b1;
      cycle(idle_sig, 2'b00, 1'b0);

      // enable -> FILL for DELAY cycles -> CHECK
      cfg_en_i = 1'b1;
      cycle(idle_sig, 2'b00, 1'b0); chk("en_fill0", 64'(state_o), 64'd1);
      cycle(idle_sig, 2'b00, 1'b0); chk("en_fill1", 64'(state_o), 64'd1);
      cycle(idle_sig, 2'b00, 1'b0); chk("en_check", 64'(state_o), 64'd2);

      // identical random streams
      for (int i = 0; i < 100; i++) begin
         rnd.req = 1'($urandom_range(0, 1)); rnd.wen = 1'($urandom_range(0, 1));
         rnd.be = 4'($urandom); rnd.addr = $urandom; rnd.wdata = $urandom;
         cycle(rnd, 2'b00, 1'b0);
      end
      chk("rand_cnt", 64'(err_cnt_o), 64'd0);
      chk("rand_fault", 64'(fault_o), 64'd0);

      // single corrupted wdata at threshold 1
      cycle(mk(1'b1, 32'h0000_1A00, 32'hDEAD_BEEF), 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b01, 1'b1);
      chk("c1_fault", 64'(fault_o), 64'd1);
      chk("c1_irq", 64'(irq_o), 64'd1);
      chk("c1_faddr", 64'(fault_addr_o), 64'h1A00);
      chk("c1_cnt", 64'(err_cnt_o), 64'd1);
      cycle(idle_sig, 2'b00, 1'b0);
      chk("c1_irq_once", 64'(irq_o), 64'd0);
      chk("c1_sticky", 64'(fault_o), 64'd1);
      // no compares while in FAULT
      cycle(mk(1'b1, 32'h2B00, 32'h1), 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b01, 1'b0);
      chk("flt_nocmp", 64'(err_cnt_o), 64'd1);

      // clear in FAULT with enable -> FILL, FILL, CHECK
      cfg_clr_i = 1'b1; cfg_thresh_i = 16'd3;
      cycle(idle_sig, 2'b00, 1'b0);
      cfg_clr_i = 1'b0;
      chk("clr_fill0", 64'(state_o), 64'd1);
      chk("clr_cnt", 64'(err_cnt_o), 64'd0);
      chk("clr_faddr", 64'(fault_addr_o), 64'd0);
      chk("clr_fault", 64'(fault_o), 64'd0);
      cycle(idle_sig, 2'b00, 1'b0); chk("clr_fill1", 64'(state_o), 64'd1);
      cycle(idle_sig, 2'b00, 1'b0); chk("clr_check", 64'(state_o), 64'd2);

      // threshold 3: three separated mismatches
      for (int i = 1; i <= 3; i++) begin
         cycle(mk(1'b1, 32'h3000 + 32'(i * 4), 32'(i)), 2'b00, 1'b0);
         cycle(idle_sig, 2'b00, 1'b0);
         cycle(idle_sig, 2'b01, 1'b1);
         chk("th3_cnt", 64'(err_cnt_o), 64'(i));
         chk("th3_irq", 64'(irq_o), 64'(i == 3));
         chk("th3_state", 64'(state_o), (i == 3) ? 64'd3 : 64'd2);
         chk("th3_faddr", 64'(fault_addr_o), 64'h3004);
      end
      cycle(idle_sig, 2'b00, 1'b0);
      chk("th3_irq_once", 64'(irq_o), 64'd0);

      // back to CHECK, one mismatch, then clear coinciding with a mismatch
      cfg_clr_i = 1'b1;
      cycle(idle_sig, 2'b00, 1'b0);
      cfg_clr_i = 1'b0;
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      chk("re_check", 64'(state_o), 64'd2);
      cycle(mk(1'b1, 32'h4000, 32'h5), 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b01, 1'b1);
      chk("pre_clr_cnt", 64'(err_cnt_o), 64'd1);
      cycle(mk(1'b1, 32'h4100, 32'h6), 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      cfg_clr_i = 1'b1;
      cycle(idle_sig, 2'b01, 1'b0);
      cfg_clr_i = 1'b0;
      chk("clrmis_cnt", 64'(err_cnt_o), 64'd0);
      chk("clrmis_state", 64'(state_o), 64'd2);
      chk("clrmis_faddr", 64'(fault_addr_o), 64'd0);

      // both requests low with differing addr/wdata
      cycle(mk(1'b0, 32'h5000, 32'h77), 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b11, 1'b0);
      chk("noreq_cnt", 64'(err_cnt_o), 64'd0);

      // threshold 0 acts as 1; then enable drop in FAULT
      cfg_thresh_i = 16'd0;
      cycle(mk(1'b1, 32'h6000, 32'h9), 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b10, 1'b1);
      chk("th0_state", 64'(state_o), 64'd3);
      chk("th0_faddr", 64'(fault_addr_o), 64'h6000);
      cfg_en_i = 1'b0;
      cycle(idle_sig, 2'b00, 1'b0);
      chk("dis_state", 64'(state_o), 64'd0);
      chk("dis_fault", 64'(fault_o), 64'd0);
      chk("dis_cnt", 64'(err_cnt_o), 64'd1);
      chk("dis_faddr", 64'(fault_addr_o), 64'h6000);

      // enable and clear together
      cfg_en_i = 1'b1; cfg_clr_i = 1'b1;
      cycle(idle_sig, 2'b00, 1'b0);
      cfg_clr_i = 1'b0;
      chk("enclr_state", 64'(state_o), 64'd1);
      chk("enclr_cnt", 64'(err_cnt_o), 64'd0);
      cycle(idle_sig, 2'b00, 1'b0);
      cycle(idle_sig, 2'b00, 1'b0);
      chk("enclr_check", 64'(state_o), 64'd2);

      // read data differs while requests match
      m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE_0001;
      cycle(idle_sig, 2'b00, 1'b0);
      m_rvalid_i = 1'b0; m_rdata_i = '0;
      cycle(idle_sig, 2'b00, 1'b0);
      s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_0000;
      cycle(idle_sig, 2'b00, RD_EXP);
      s_rvalid_i = 1'b0; s_rdata_i = '0;
      chk("rd_cnt", 64'(err_cnt_o), 64'(RD_EXP));
      cycle(idle_sig, 2'b00, 1'b0);

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
